// File: rtl/traffic_light_ctrl.sv
// Main-road / farm-road intersection phase sequencer: phase timer, light FSM, registered lamp decode.
// Optional pedestrian walk phase is enabled by defining TRAFFIC_PED_EN.
module traffic_light_ctrl #(
  parameter int CNT_W    = 5,
  parameter int T_MAIN_G = 30,
  parameter int T_FARM_G = 15,
  parameter int T_YEL    = 5,
  parameter int T_ALLR   = 2,
  parameter int T_PED    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             farm_req,
`ifdef TRAFFIC_PED_EN
  input  logic             ped_req,
  output logic             walk,
`endif
  output logic [2:0]       main_light,
  output logic [2:0]       farm_light,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_done
);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    ALLR1  = 3'd2,
    FARM_G = 3'd3,
    FARM_Y = 3'd4,
    ALLR2  = 3'd5,
    PED_W  = 3'd6
  } state_t;

  state_t           state_r;
  state_t           next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             req_pend_r;
  logic             req_next_s;
  logic             at_lim_s;
  logic             exit_s;
  logic             release_s;
  logic [5:0]       lights_next_s;
`ifdef TRAFFIC_PED_EN
  logic             ped_pend_r;
  logic             ped_next_s;
`endif

  function automatic logic [CNT_W-1:0] last_cnt_f(input state_t s);
    case (s)
      MAIN_G:         last_cnt_f = CNT_W'(T_MAIN_G - 1);
      MAIN_Y, FARM_Y: last_cnt_f = CNT_W'(T_YEL - 1);
      ALLR1, ALLR2:   last_cnt_f = CNT_W'(T_ALLR - 1);
      FARM_G:         last_cnt_f = CNT_W'(T_FARM_G - 1);
      PED_W:          last_cnt_f = CNT_W'(T_PED - 1);
      default:        last_cnt_f = {CNT_W{1'b0}};
    endcase
  endfunction

  // {main, farm} lamps; anything unrecognised decodes to all red.
  function automatic logic [5:0] lights_f(input state_t s);
    case (s)
      MAIN_G:  lights_f = {3'b001, 3'b100};
      MAIN_Y:  lights_f = {3'b010, 3'b100};
      FARM_G:  lights_f = {3'b100, 3'b001};
      FARM_Y:  lights_f = {3'b100, 3'b010};
      default: lights_f = {3'b100, 3'b100};
    endcase
  endfunction

  // Next-state selection and exit strobe.
  always_comb begin
    next_s   = state_r;
    exit_s   = 1'b0;
    at_lim_s = (cnt_r == last_cnt_f(state_r));
`ifdef TRAFFIC_PED_EN
    release_s = req_pend_r | farm_req | ped_pend_r | ped_req;
`else
    release_s = req_pend_r | farm_req;
`endif
    case (state_r)
      MAIN_G: if (at_lim_s && release_s) next_s = MAIN_Y; else next_s = MAIN_G;
      MAIN_Y: if (at_lim_s) next_s = ALLR1; else next_s = MAIN_Y;
`ifdef TRAFFIC_PED_EN
      ALLR1: begin
        if (at_lim_s && (req_pend_r || farm_req)) next_s = FARM_G;
        else if (at_lim_s) next_s = ALLR2;
        else next_s = ALLR1;
      end
`else
      ALLR1:  if (at_lim_s) next_s = FARM_G; else next_s = ALLR1;
`endif
      FARM_G: if (at_lim_s) next_s = FARM_Y; else next_s = FARM_G;
      FARM_Y: if (at_lim_s) next_s = ALLR2; else next_s = FARM_Y;
`ifdef TRAFFIC_PED_EN
      ALLR2: begin
        if (at_lim_s && ped_pend_r) next_s = PED_W;
        else if (at_lim_s) next_s = MAIN_G;
        else next_s = ALLR2;
      end
      PED_W:  if (at_lim_s) next_s = MAIN_G; else next_s = PED_W;
`else
      ALLR2:  if (at_lim_s) next_s = MAIN_G; else next_s = ALLR2;
`endif
      default: next_s = ALLR2;
    endcase
    exit_s = (next_s != state_r);
  end

  // Timer and request-latch next values; a new request beats the entry clear.
  always_comb begin
    cnt_next_s    = cnt_r + CNT_W'(1);
    req_next_s    = req_pend_r;
    lights_next_s = lights_f(next_s);
    if (exit_s) cnt_next_s = {CNT_W{1'b0}};
    else if (state_r == MAIN_G && at_lim_s) cnt_next_s = cnt_r;
    else cnt_next_s = cnt_r + CNT_W'(1);
    if (farm_req) req_next_s = 1'b1;
    else if (exit_s && next_s == FARM_G) req_next_s = 1'b0;
    else req_next_s = req_pend_r;
`ifdef TRAFFIC_PED_EN
    ped_next_s = ped_pend_r;
    if (ped_req) ped_next_s = 1'b1;
    else if (exit_s && next_s == PED_W) ped_next_s = 1'b0;
    else ped_next_s = ped_pend_r;
`endif
  end

  // State, timer, request latches and registered lamp outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= MAIN_G;
      cnt_r      <= {CNT_W{1'b0}};
      req_pend_r <= 1'b0;
      main_light <= 3'b001;
      farm_light <= 3'b100;
`ifdef TRAFFIC_PED_EN
      ped_pend_r <= 1'b0;
      walk       <= 1'b0;
`endif
    end else begin
      state_r    <= next_s;
      cnt_r      <= cnt_next_s;
      req_pend_r <= req_next_s;
      main_light <= lights_next_s[5:3];
      farm_light <= lights_next_s[2:0];
`ifdef TRAFFIC_PED_EN
      ped_pend_r <= ped_next_s;
      walk       <= (next_s == PED_W);
`endif
    end
  end

  assign state      = state_r;
  assign phase_cnt  = cnt_r;
  assign phase_done = exit_s;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed self-checking bench for traffic_light_ctrl; pedestrian scenario runs when TRAFFIC_PED_EN is defined.
module tb_traffic_light_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       farm_req = 1'b0;
  logic       ped_req = 1'b0;
  logic       walk;
  logic [2:0] main_light, farm_light, state;
  logic [4:0] phase_cnt;
  logic       phase_done;
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk(clk), .rst_n(rst_n), .farm_req(farm_req),
`ifdef TRAFFIC_PED_EN
    .ped_req(ped_req), .walk(walk),
`endif
    .main_light(main_light), .farm_light(farm_light), .state(state),
    .phase_cnt(phase_cnt), .phase_done(phase_done)
  );
`ifndef TRAFFIC_PED_EN
  assign walk = 1'b0;
`endif

  // Hand-derived schedule: y1/y2 are the cycles MAIN_Y is entered, ped selects the walk path.
  function automatic void exp_at(input int k, input int y1, input int y2, input bit ped,
                                 output logic [2:0] st, output int cnt);
    int b, d;
    if (y2 >= 0 && k >= y2) b = y2; else if (y1 >= 0 && k >= y1) b = y1; else b = -1;
    if (b < 0) begin st = 3'd0; cnt = (k > 29) ? 29 : k; end
    else begin
      d = k - b;
      if (d < 5)                   begin st = 3'd1; cnt = d;      end
      else if (d < 7)              begin st = 3'd2; cnt = d - 5;  end
      else if (ped && d < 9)       begin st = 3'd5; cnt = d - 7;  end
      else if (ped && d < 19)      begin st = 3'd6; cnt = d - 9;  end
      else if (ped)                begin st = 3'd0; cnt = (d - 19 > 29) ? 29 : d - 19; end
      else if (d < 22)             begin st = 3'd3; cnt = d - 7;  end
      else if (d < 27)             begin st = 3'd4; cnt = d - 22; end
      else if (d < 29)             begin st = 3'd5; cnt = d - 27; end
      else                         begin st = 3'd0; cnt = (d - 29 > 29) ? 29 : d - 29; end
    end
  endfunction

  function automatic logic [5:0] exp_lights(input logic [2:0] st);
    case (st)
      3'd0:    exp_lights = 6'b001_100;
      3'd1:    exp_lights = 6'b010_100;
      3'd3:    exp_lights = 6'b100_001;
      3'd4:    exp_lights = 6'b100_010;
      default: exp_lights = 6'b100_100;
    endcase
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; farm_req = 1'b0; ped_req = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state); end
    n_checks++; if (phase_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", phase_cnt); end
    n_checks++; if (main_light !== 3'b001) begin n_fail++; $display("FAIL reset_main got=%b exp=001", main_light); end
    n_checks++; if (farm_light !== 3'b100) begin n_fail++; $display("FAIL reset_farm got=%b exp=100", farm_light); end
    n_checks++; if (phase_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", phase_done); end
    n_checks++; if (walk !== 1'b0) begin n_fail++; $display("FAIL reset_walk got=%b exp=0", walk); end
    @(negedge clk);
  endtask

  // Scenario runner: reset, pulse farm_req at fp1/fp2 and ped_req at pp, compare every cycle.
  task automatic run_schedule(input string name, input int ncyc, input int fp1, input int fp2,
                              input int pp, input int y1, input int y2, input bit ped);
    logic [2:0] st, st_n;
    int cnt, cnt_n, walks;
    walks = 0;
    do_reset();
    for (int k = 0; k < ncyc; k++) begin
      farm_req = (k == fp1 || k == fp2);
      ped_req  = (k == pp);
      #1;
      exp_at(k, y1, y2, ped, st, cnt);
      exp_at(k + 1, y1, y2, ped, st_n, cnt_n);
      n_checks++;
      if (state !== st || phase_cnt !== 5'(cnt) || phase_done !== (st_n != st) ||
          {main_light, farm_light} !== exp_lights(st) || walk !== (st == 3'd6)) begin
        n_fail++;
        $display("FAIL %s cycle=%0d got st=%0d cnt=%0d done=%b lights=%b_%b walk=%b exp st=%0d cnt=%0d done=%b lights=%b walk=%b",
                 name, k, state, phase_cnt, phase_done, main_light, farm_light, walk,
                 st, cnt, (st_n != st), exp_lights(st), (st == 3'd6));
      end
      if (walk === 1'b1) walks++;
      @(negedge clk);
    end
    farm_req = 1'b0; ped_req = 1'b0;
    if (ped) begin
      n_checks++; if (walks != 10) begin n_fail++; $display("FAIL %s_walk_len got=%0d exp=10", name, walks); end
    end
  endtask

  task automatic test_idle();
    run_schedule("idle", 100, -1, -1, -1, -1, -1, 1'b0);
  endtask

  task automatic test_farm_cycle();
    run_schedule("farm_cycle", 100, 3, -1, -1, 30, -1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_schedule("back_to_back", 125, 3, 40, -1, 30, 89, 1'b0);
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int k = 0; k < 40; k++) begin
      farm_req = (k == 3);
      @(negedge clk);
    end
    farm_req = 1'b0;
    #1;
    n_checks++; if (state !== 3'd3) begin n_fail++; $display("FAIL midrst_pre got=%0d exp=3", state); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (state !== 3'd0 || main_light !== 3'b001 || farm_light !== 3'b100 || phase_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL midrst got st=%0d main=%b farm=%b cnt=%0d exp st=0 main=001 farm=100 cnt=0",
               state, main_light, farm_light, phase_cnt);
    end
    for (int k = 0; k < 35; k++) @(negedge clk);
    #1;
    n_checks++;
    if (state !== 3'd0 || phase_cnt !== 5'd29) begin
      n_fail++; $display("FAIL midrst_rest got st=%0d cnt=%0d exp st=0 cnt=29", state, phase_cnt);
    end
  endtask

  task automatic test_random();
    logic [2:0] prev_st;
    logic       prev_done;
    int         dones, changes;
    dones = 0; changes = 0;
    do_reset();
    prev_st = 3'd0; prev_done = 1'b0;
    for (int k = 0; k < 800; k++) begin
      farm_req = ($urandom_range(0, 19) == 0);
      #1;
      if (k > 0) begin
        if (state != prev_st) changes++;
        n_checks++;
        if ((state != prev_st) !== prev_done) begin
          n_fail++; $display("FAIL rand_done cycle=%0d got done=%b exp=%b", k - 1, prev_done, (state != prev_st));
        end
        if (state != prev_st) begin
          n_checks++;
          if (phase_cnt !== 5'd0) begin n_fail++; $display("FAIL rand_cnt_clr cycle=%0d got=%0d exp=0", k, phase_cnt); end
        end
      end
      n_checks++;
      if ((main_light != 3'b100 && farm_light != 3'b100) || {main_light, farm_light} !== exp_lights(state)) begin
        n_fail++; $display("FAIL rand_lights cycle=%0d st=%0d got=%b_%b exp=%b", k, state, main_light, farm_light, exp_lights(state));
      end
      if (phase_done === 1'b1) dones++;
      prev_st = state; prev_done = phase_done;
      @(negedge clk);
    end
    farm_req = 1'b0;
    #1;
    if (state != prev_st) changes++;
    n_checks++;
    if (dones != changes) begin n_fail++; $display("FAIL rand_count got dones=%0d exp=%0d", dones, changes); end
  endtask

`ifdef TRAFFIC_PED_EN
  task automatic test_ped();
    run_schedule("ped", 90, -1, -1, 3, 30, -1, 1'b1);
  endtask
`endif

  initial begin
    test_reset();
    test_idle();
    test_farm_cycle();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef TRAFFIC_PED_EN
    test_ped();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
